// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: four-digit BCD up/down counter with multiplexed display scanner
module bcd_scan_counter #(
    parameter int COUNT_DIV = 50_000_000,
    parameter int SCAN_DIV  = 50_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        up,
    input  logic        clear,
    input  logic        blank_lz,
    output logic [3:0]  digit_data,
    output logic [3:0]  anode,
    output logic [15:0] count_bcd,
    output logic        carry
);
    localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [PW-1:0] pre;
    logic [SW-1:0] scan;
    logic [1:0]    idx;
    logic [1:0]    next_idx;
    logic          step;
    logic          scan_wrap;
    logic          ripple;
    logic [15:0]   next_count;
    logic [15:0]   upper;
    logic          blank;

    assign step      = en && pre == PRE_MAX;
    assign scan_wrap = scan == SCAN_MAX;
    assign next_idx  = scan_wrap ? idx + 2'd1 : idx;
    assign upper     = count_bcd >> {next_idx, 2'b00};
    assign blank     = blank_lz && next_idx != 2'd0 && upper == 16'h0000;

    // Decimal increment/decrement with carry/borrow rippling up through the digits
    always_comb begin
        next_count = count_bcd;
        ripple     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (ripple) begin
                if (up) begin
                    next_count[4*k +: 4] = count_bcd[4*k +: 4] == 4'd9 ? 4'd0 : count_bcd[4*k +: 4] + 4'd1;
                    ripple               = count_bcd[4*k +: 4] == 4'd9;
                end else begin
                    next_count[4*k +: 4] = count_bcd[4*k +: 4] == 4'd0 ? 4'd9 : count_bcd[4*k +: 4] - 4'd1;
                    ripple               = count_bcd[4*k +: 4] == 4'd0;
                end
            end
        end
    end

    // Prescaler, count and wrap pulse; clear overrides any due step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre       <= '0;
            count_bcd <= 16'h0000;
            carry     <= 1'b0;
        end else if (clear) begin
            pre       <= '0;
            count_bcd <= 16'h0000;
            carry     <= 1'b0;
        end else begin
            carry <= step && ripple;
            if (step) begin
                pre       <= '0;
                count_bcd <= next_count;
            end else if (en) begin
                pre <= pre + 1'b1;
            end
        end
    end

    // Free-running scanner; anode and digit are built from the index about to take effect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan       <= '0;
            idx        <= 2'd0;
            anode      <= 4'b1110;
            digit_data <= 4'h0;
        end else begin
            scan       <= scan_wrap ? '0 : scan + 1'b1;
            idx        <= next_idx;
            anode      <= ~(4'b0001 << next_idx);
            digit_data <= blank ? 4'hF : upper[3:0];
        end
    end
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: randomized check of bcd_scan_counter against an arithmetic model
module tb_bcd_scan_counter;
    localparam int CD = 4;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        clear = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  digit_data;
    logic [3:0]  anode;
    logic [15:0] count_bcd;
    logic        carry;

    int checks = 0;
    int failures = 0;
    int m_cnt, m_pre, m_scan, carries;
    logic        m_carry;
    logic [3:0]  m_anode, m_digit;
    int pw [4] = '{1, 10, 100, 1000};

    bcd_scan_counter #(.COUNT_DIV(CD), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .blank_lz(blank_lz),
        .digit_data(digit_data), .anode(anode), .count_bcd(count_bcd), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_scan = 0; m_carry = 0;
        m_anode = 4'b1110; m_digit = 4'h0;
    endtask

    task automatic compare_all();
        check("count", count_bcd, to_bcd(m_cnt));
        check("carry", {15'd0, carry}, {15'd0, m_carry});
        check("anode", {12'd0, anode}, {12'd0, m_anode});
        check("digit", {12'd0, digit_data}, {12'd0, m_digit});
    endtask

    task automatic tick();
        int i;
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            m_scan++;
            i = (m_scan / SD) % 4;
            m_anode = ~(4'b0001 << i);
            m_digit = (blank_lz && i > 0 && m_cnt < pw[i]) ? 4'hF : 4'((m_cnt / pw[i]) % 10);
            m_carry = 0;
            if (clear) begin
                m_cnt = 0; m_pre = 0;
            end else if (en) begin
                if (m_pre == CD - 1) begin
                    m_pre = 0;
                    if (up) begin
                        m_carry = m_cnt == 9999;
                        m_cnt = (m_cnt + 1) % 10000;
                    end else begin
                        m_carry = m_cnt == 0;
                        m_cnt = (m_cnt + 9999) % 10000;
                    end
                end else m_pre++;
            end
        end
        #1;
        if (carry) carries++;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        #1 compare_all();
        run(3);
        reset_n = 1'b1;
        en = 1'b1; up = 1'b1;
        run(10 * CD);
        check("ten_steps", count_bcd, 16'h0010);
        // full up wrap with carry pulse, passing 0099->0100 on the way
        clear = 1'b1; tick(); clear = 1'b0;
        carries = 0;
        run(10000 * CD);
        check("up_wrap_val", count_bcd, 16'h0000);
        check("up_wrap_carries", 16'(carries), 16'd1);
        // down wrap from 0000
        clear = 1'b1; tick(); clear = 1'b0;
        up = 1'b0; carries = 0;
        run(CD);
        check("down_wrap_val", count_bcd, 16'h9999);
        check("down_wrap_carries", 16'(carries), 16'd1);
        // prescaler freeze across en low
        up = 1'b1; clear = 1'b1; tick(); clear = 1'b0;
        run(3); en = 1'b0; run(5);
        check("pre_hold", count_bcd, 16'h0000);
        en = 1'b1; tick();
        check("pre_one_step", count_bcd, 16'h0001);
        // clear on the same edge as a due step
        run(CD - 1);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_prio", count_bcd, 16'h0000);
        check("clear_carry", {15'd0, carry}, 16'd0);
        run(CD - 1);
        check("clear_no_early", count_bcd, 16'h0000);
        tick();
        check("clear_next_step", count_bcd, 16'h0001);
        // blanking at 0045 and 0000
        clear = 1'b1; tick(); clear = 1'b0;
        run(45 * CD); en = 1'b0;
        check("at_45", count_bcd, 16'h0045);
        blank_lz = 1'b1; run(8 * SD);
        blank_lz = 1'b0; run(8 * SD);
        clear = 1'b1; tick(); clear = 1'b0;
        blank_lz = 1'b1; run(8 * SD);
        // randomized traffic with occasional async reset
        for (int r = 0; r < 4000; r++) begin
            en = $urandom_range(0, 3) != 0;
            up = $urandom_range(0, 1);
            clear = $urandom_range(0, 60) == 0;
            if ($urandom_range(0, 20) == 0) blank_lz = $urandom_range(0, 1);
            if ($urandom_range(0, 500) == 0) begin
                #2 reset_n = 1'b0;
                model_reset();
                #1 compare_all();
                tick();
                reset_n = 1'b1;
            end else tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
